// File: rtl/restoring_remultiplier.sv
// rtl/restoring_remultiplier.sv - shift-add multiplier rebuilding x = q*y + r, one multiplier bit per clock
// Optional operand-consistency flag rem_err is built when REMULT_REM_CHECK_EN is defined.
module restoring_remultiplier #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   y,
  input  logic [W-1:0]   r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] x
`ifdef REMULT_REM_CHECK_EN
  ,
  output logic           rem_err
`endif
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = BUSY;
      end
      BUSY: begin
        if (cnt == LAST_STEP) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Always W steps: the remainder preloads acc, so no final add is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= {{W{1'b0}}, r};
            mcand  <= {{W{1'b0}}, y};
            mplier <= q;
            cnt    <= '0;
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign x = acc;

`ifdef REMULT_REM_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_err <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      rem_err <= (y == '0) | (r >= y);
    end else if (state == DONE && out_ready) begin
      rem_err <= 1'b0;
    end
  end
`endif

endmodule
